// File: rtl/guess_if.sv
// Keyboard-side bundle of guess_input: raw PS/2 lines and game-state context in,
// letter load / repeat / frame-error pulses out.
interface guess_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        enable;
  logic [25:0] current_state;
  logic        load;
  logic [4:0]  load_x;
  logic        repeat_guess;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data, enable, current_state,
    input  load, load_x, repeat_guess, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, enable, current_state,
    output load, load_x, repeat_guess, frame_err
  );
endinterface

// File: rtl/guess_input.sv
// PS/2 Set-2 receiver that turns letter make codes A-Z into a one-cycle load of a 5-bit index.
// Optional macro GUESS_DUP_FILTER_EN: letters already set in current_state pulse repeat_guess instead.
module guess_input #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic   clk,
  input logic   reset,
  guess_if.slave bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         clk_sync, data_sync;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [7:0]         shift_q, shift_nxt;
  logic               par_q, par_nxt;
  logic [TO_W-1:0]    to_cnt, to_nxt;
  logic               brk, brk_nxt;
  logic               ext, ext_nxt;
  logic               load_q, load_nxt;
  logic [IDX_W-1:0]   load_x_q, load_x_nxt;
  logic               rep_q, rep_nxt;
  logic               err_q, err_nxt;

  logic               fall_c;
  logic               bit_c;
  logic [IDX_W:0]     lk_c;

  // Set-2 make code to {valid, letter index}
  function automatic logic [IDX_W:0] lookup(input logic [7:0] code);
    logic [IDX_W:0] r;
    case (code)
      8'h1C: r = {1'b1, 5'd0};
      8'h32: r = {1'b1, 5'd1};
      8'h21: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};
      8'h24: r = {1'b1, 5'd4};
      8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};
      8'h33: r = {1'b1, 5'd7};
      8'h43: r = {1'b1, 5'd8};
      8'h3B: r = {1'b1, 5'd9};
      8'h42: r = {1'b1, 5'd10};
      8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};
      8'h31: r = {1'b1, 5'd13};
      8'h44: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};
      8'h15: r = {1'b1, 5'd16};
      8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};
      8'h2C: r = {1'b1, 5'd19};
      8'h3C: r = {1'b1, 5'd20};
      8'h2A: r = {1'b1, 5'd21};
      8'h1D: r = {1'b1, 5'd22};
      8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};
      8'h1A: r = {1'b1, 5'd25};
      default: r = {1'b0, 5'd0};
    endcase
    return r;
  endfunction

  assign fall_c = clk_sync[1] & ~clk_sync[0];
  assign bit_c  = data_sync[1];
  assign lk_c   = lookup(shift_q);

  assign bus.load         = load_q;
  assign bus.load_x       = load_x_q;
  assign bus.repeat_guess = rep_q;
  assign bus.frame_err    = err_q;

`ifndef GUESS_DUP_FILTER_EN
  logic unused_state;
  assign unused_state = ^bus.current_state;
`endif

  // State and output registers; synchronizers idle high so reset cannot fake an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      bit_cnt   <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      to_cnt    <= TO_W'(0);
      brk       <= 1'b0;
      ext       <= 1'b0;
      load_q    <= 1'b0;
      load_x_q  <= IDX_W'(0);
      rep_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      bit_cnt   <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
      par_q     <= par_nxt;
      to_cnt    <= to_nxt;
      brk       <= brk_nxt;
      ext       <= ext_nxt;
      load_q    <= load_nxt;
      load_x_q  <= load_x_nxt;
      rep_q     <= rep_nxt;
      err_q     <= err_nxt;
    end
  end

  // Frame receiver, timeout and byte decode
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_nxt     = par_q;
    to_nxt      = to_cnt;
    brk_nxt     = brk;
    ext_nxt     = ext;
    load_nxt    = 1'b0;
    load_x_nxt  = load_x_q;
    rep_nxt     = 1'b0;
    err_nxt     = 1'b0;

    if (fall_c) begin
      to_nxt = TO_W'(0);
      case (state)
        S_IDLE: begin
          if (!bit_c) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            err_nxt = 1'b1;
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end
        end
        S_DATA: begin
          shift_nxt   = {bit_c, shift_q[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_nxt   = bit_c;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (bit_c && (^{shift_q, par_q})) begin
            if (shift_q == 8'hF0) begin
              brk_nxt = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_nxt = 1'b1;
            end else if (brk || ext) begin
              brk_nxt = 1'b0;
              ext_nxt = 1'b0;
            end else if (lk_c[IDX_W] && bus.enable) begin
`ifdef GUESS_DUP_FILTER_EN
              if (bus.current_state[lk_c[IDX_W-1:0]]) begin
                rep_nxt = 1'b1;
              end else begin
                load_nxt   = 1'b1;
                load_x_nxt = lk_c[IDX_W-1:0];
              end
`else
              load_nxt   = 1'b1;
              load_x_nxt = lk_c[IDX_W-1:0];
`endif
            end
          end else begin
            err_nxt = 1'b1;
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      // A stalled keyboard must not wedge the receiver mid-frame
      if (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
        err_nxt   = 1'b1;
        state_nxt = S_IDLE;
        brk_nxt   = 1'b0;
        ext_nxt   = 1'b0;
        to_nxt    = TO_W'(0);
      end else begin
        to_nxt = to_cnt + TO_W'(1);
      end
    end else begin
      to_nxt = TO_W'(0);
    end
  end

endmodule

// File: tb/tb_guess_input.sv
// Directed bench for guess_input: PS/2 frames bit-banged at 20 clk half-period, pulses counted.
module tb_guess_input;

  localparam int HALF = 20;

  logic clk;
  logic reset;
  guess_if bus();

  guess_input #(.TIMEOUT_CYCLES(200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_load = 0;
  int n_rep = 0;
  int n_err = 0;
  int n_multi = 0;
  int l0, r0, e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load) n_load++;
      if (bus.repeat_guess) n_rep++;
      if (bus.frame_err) n_err++;
      if ((bus.load & bus.repeat_guess) | (bus.load & bus.frame_err) |
          (bus.repeat_guess & bus.frame_err)) n_multi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    l0 = n_load;
    r0 = n_rep;
    e0 = n_err;
  endtask

  task automatic ps2_send(input logic [7:0] b, input logic bad_par, input logic stop_b,
                          input int nbits);
    logic [10:0] fr;
    fr = {stop_b, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    if (nbits == 11) bus.ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_send(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    reset             = 1'b1;
    bus.ps2_clk       = 1'b1;
    bus.ps2_data      = 1'b1;
    bus.enable        = 1'b1;
    bus.current_state = 26'd0;
    repeat (5) @(negedge clk);
    check("rst_load", 32'(bus.load), 0);
    check("rst_load_x", 32'(bus.load_x), 0);
    check("rst_repeat", 32'(bus.repeat_guess), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Letter A then Z
    snap();
    send(8'h1C);
    check("a_load_cnt", 32'(n_load - l0), 1);
    check("a_load_x", 32'(bus.load_x), 0);
    send(8'h1A);
    check("z_load_cnt", 32'(n_load - l0), 2);
    check("z_load_x", 32'(bus.load_x), 25);
    check("az_err_cnt", 32'(n_err - e0), 0);

    // Make, break, make of E: only the first frame loads
    snap();
    send(8'h24);
    send(8'hF0);
    send(8'h24);
    check("brk_load_cnt", 32'(n_load - l0), 1);
    check("brk_load_x", 32'(bus.load_x), 4);

    // Extended prefix suppresses the following letter
    snap();
    send(8'hE0);
    send(8'h1C);
    check("ext_load_cnt", 32'(n_load - l0), 0);
    check("ext_load_x", 32'(bus.load_x), 4);

    // Bad parity, then bad stop bit
    snap();
    ps2_send(8'h2D, 1'b1, 1'b1, 11);
    check("par_err_cnt", 32'(n_err - e0), 1);
    check("par_load_cnt", 32'(n_load - l0), 0);
    check("par_load_x", 32'(bus.load_x), 4);
    ps2_send(8'h2D, 1'b0, 1'b0, 11);
    bus.ps2_data = 1'b1;
    check("stop_err_cnt", 32'(n_err - e0), 2);
    check("stop_load_cnt", 32'(n_load - l0), 0);

    // Stalled frame times out once, receiver recovers
    snap();
    ps2_send(8'h15, 1'b0, 1'b1, 5);
    repeat (250) @(negedge clk);
    bus.ps2_data = 1'b1;
    check("to_err_cnt", 32'(n_err - e0), 1);
    check("to_load_cnt", 32'(n_load - l0), 0);
    send(8'h15);
    check("q_load_cnt", 32'(n_load - l0), 1);
    check("q_load_x", 32'(bus.load_x), 16);
    check("q_err_cnt", 32'(n_err - e0), 1);

    // Already-guessed A
    snap();
    bus.current_state = 26'h0000001;
    send(8'h1C);
    bus.current_state = 26'd0;
`ifdef GUESS_DUP_FILTER_EN
    check("dup_rep_cnt", 32'(n_rep - r0), 1);
    check("dup_load_cnt", 32'(n_load - l0), 0);
    check("dup_load_x", 32'(bus.load_x), 16);
`else
    check("dup_rep_cnt", 32'(n_rep - r0), 0);
    check("dup_load_cnt", 32'(n_load - l0), 1);
    check("dup_load_x", 32'(bus.load_x), 0);
`endif

    // Disabled: frame parsed, nothing issued
    snap();
    bus.enable = 1'b0;
    send(8'h44);
    bus.enable = 1'b1;
    check("dis_load_cnt", 32'(n_load - l0), 0);
    check("dis_rep_cnt", 32'(n_rep - r0), 0);
    check("dis_err_cnt", 32'(n_err - e0), 0);

    // Reset in the middle of a frame
    ps2_send(8'h44, 1'b0, 1'b1, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_load", 32'(bus.load), 0);
    check("mid_rst_load_x", 32'(bus.load_x), 0);
    check("mid_rst_repeat", 32'(bus.repeat_guess), 0);
    check("mid_rst_frame_err", 32'(bus.frame_err), 0);
    bus.ps2_data = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    snap();
    send(8'h44);
    check("o_load_cnt", 32'(n_load - l0), 1);
    check("o_load_x", 32'(bus.load_x), 14);
    check("o_err_cnt", 32'(n_err - e0), 0);

    check("pulse_exclusive", 32'(n_multi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/guess_input.md
# guess_input

Upstream stage of the game state register: receives a PS/2 keyboard, decodes Set-2 make codes for letters A–Z into a 5-bit letter index, and issues a single-cycle `load` with `load_x` to the game state block. Break and extended sequences, non-letter keys and malformed frames never produce a load. Already-guessed letters can optionally be filtered out using the game state's `current_state` vector.

## Interface
- `TIMEOUT_CYCLES`, 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset; clock `clk`.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `enable` input 1: when low, frames are still parsed but no `load`/`repeat_guess` is issued.
- `current_state` input 26: guessed-letter vector from game state; bit i = letter i already guessed.
- `load` output 1: one-cycle pulse, accepted letter.
- `load_x` output 5: letter index 0 (A) to 25 (Z); held until the next `load`.
- `repeat_guess` output 1: one-cycle pulse, letter rejected as already guessed.
- `frame_err` output 1: one-cycle pulse on start/parity/stop/timeout error.

## Operation
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer; a falling edge is detected on the synchronized clock (sync[1]=1, sync[0]=0 of the previous and current samples).
- Receiver FSM, one data sample per detected falling edge:
  - IDLE: start bit must be 0 → DATA; 1 → `frame_err`, stay IDLE.
  - DATA: shift 8 bits, LSB first → PARITY.
  - PARITY: store bit; odd parity over data+parity required → STOP.
  - STOP: bit must be 1 and parity good → byte valid, return to IDLE; otherwise `frame_err`, discard, return to IDLE.
- Timeout counter clears on every falling edge; in any state other than IDLE, reaching `TIMEOUT_CYCLES` → `frame_err`, return to IDLE, clear prefix flags.
- Byte handling (in order):
  - 0xF0: set `brk`. 0xE0: set `ext`.
  - Any other byte with `brk` or `ext` set: discarded, both flags cleared.
  - Otherwise lookup: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A; non-letters discarded silently.
  - Letter with `enable`=1 → `load` (or `repeat_guess`, see Configuration); with `enable`=0 → discarded.
- Any frame error also clears `brk` and `ext`.

## Timing
- Reset values: `load`=0, `load_x`=0, `repeat_guess`=0, `frame_err`=0, FSM IDLE, `brk`=`ext`=0, timeout counter 0.
- Latency: stop-bit falling edge detected in cycle N → `load`/`repeat_guess`/`frame_err` asserted in cycle N+1 for exactly one cycle; `load_x` updates in the same cycle as `load`.
- `load`, `repeat_guess`, and `frame_err` are mutually exclusive.
- `current_state` and `enable` are sampled in cycle N.
- Reset mid-frame discards the partial byte; the next frame must start at its start bit.

## Configuration
- `GUESS_DUP_FILTER_EN` defined: letter with `current_state[idx]`=1 → `repeat_guess` pulse, no `load`, `load_x` unchanged.
- `GUESS_DUP_FILTER_EN` undefined: `current_state` ignored; every letter → `load`; `repeat_guess` tied 0.

## Test plan
Bench settings: `TIMEOUT_CYCLES`=200, PS/2 half-period 20 clk.
- Frame 0x1C, good parity, `enable`=1 → single `load` pulse with `load_x`=0; then 0x1A → `load_x`=25.
- Sequence 0x24, 0xF0, 0x24 → exactly one `load` (`load_x`=4); the break frame gives none. Sequence 0xE0, 0x1C → no `load`.
- 0x2D with bad parity → `frame_err` pulse, no `load`, `load_x` unchanged. Stop bit 0 → `frame_err`.
- Stop `ps2_clk` after 5 bits for 250 cycles → `frame_err` once; next good 0x15 → `load_x`=16.
- `GUESS_DUP_FILTER_EN` defined, `current_state`=26'h0000001, frame 0x1C → `repeat_guess`, no `load`; undefined → `load`, `load_x`=0.
- `enable`=0 with frame 0x44 → no output; `reset` asserted mid-frame → all outputs 0, next complete 0x44 → `load_x`=14.
